// File: rtl/alu_issue_ctrl.sv
// Issue/capture sequencer for the 32-bit ALU: decodes one instruction per
// input handshake, drives A/B/OP from registers and returns RES on an output handshake.
module alu_issue_ctrl (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        IN_VALID,
  output logic        IN_READY,
  input  logic [1:0]  ALU_OP_SEL,
  input  logic [5:0]  FUNCT,
  input  logic [31:0] RS_DATA,
  input  logic [31:0] RT_DATA,
  output logic [31:0] A,
  output logic [31:0] B,
  output logic [3:0]  OP,
  input  logic [31:0] RES,
  output logic        OUT_VALID,
  input  logic        OUT_READY,
  output logic [31:0] OUT_RES,
  output logic        ZERO,
  output logic        ILLEGAL,
  output logic [15:0] DONE_CNT
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;
  localparam logic [3:0] OP_BAD = 4'b1111;

  state_t      state;
  state_t      state_nxt;

  // Issue stage (drives the ALU)
  logic [31:0] a_p0;
  logic [31:0] b_p0;
  logic [3:0]  op_p0;
  logic        ill_p0;

  // Result stage (presented to writeback)
  logic [31:0] res_p1;
  logic        zero_p1;
  logic        ill_p1;
  logic        vld_p1;

  logic [15:0] done_cnt;

  logic        ready_c;
  logic        accept;
  logic        take;
  logic [3:0]  dec_op;
  logic        dec_ill;

  // Returns {illegal, opcode}; unknown encodings map to the ALU's null op.
  function automatic logic [4:0] decode(input logic [1:0] sel, input logic [5:0] funct);
    logic [4:0] r;
    r = {1'b1, OP_BAD};
    unique case (sel)
      2'b00: r = {1'b0, OP_ADD};
      2'b01: r = {1'b0, OP_SUB};
      2'b10: begin
        unique case (funct)
          6'b100000: r = {1'b0, OP_ADD};
          6'b100010: r = {1'b0, OP_SUB};
          6'b100100: r = {1'b0, OP_AND};
          6'b100101: r = {1'b0, OP_OR};
          6'b101010: r = {1'b0, OP_SLT};
          6'b100111: r = {1'b0, OP_NOR};
          default:   r = {1'b1, OP_BAD};
        endcase
      end
      default: r = {1'b1, OP_BAD};
    endcase
    return r;
  endfunction

  assign {dec_ill, dec_op} = decode(ALU_OP_SEL, FUNCT);

  // A consumer taking the result in DONE frees the slot in the same cycle.
  assign ready_c  = (state == IDLE) || ((state == DONE) && OUT_READY);
  assign IN_READY = RST_N && ready_c;
  assign accept   = IN_VALID && IN_READY;
  assign take     = (state == DONE) && OUT_READY;

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (accept) state_nxt = EXEC;
      EXEC: state_nxt = DONE;
      DONE: begin
        if (OUT_READY) state_nxt = accept ? EXEC : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // p0: operands held between accepts so the ALU inputs stay quiet
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      a_p0   <= '0;
      b_p0   <= '0;
      op_p0  <= OP_AND;
      ill_p0 <= 1'b0;
    end else if (accept) begin
      a_p0   <= RS_DATA;
      b_p0   <= RT_DATA;
      op_p0  <= dec_op;
      ill_p0 <= dec_ill;
    end
  end

  // p1: ALU result captured one cycle after issue
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      res_p1  <= '0;
      zero_p1 <= 1'b0;
      ill_p1  <= 1'b0;
      vld_p1  <= 1'b0;
    end else if (state == EXEC) begin
      res_p1  <= RES;
      zero_p1 <= (RES == 32'd0);
      ill_p1  <= ill_p0;
      vld_p1  <= 1'b1;
    end else if (take) begin
      vld_p1  <= 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      done_cnt <= '0;
    end else if (take) begin
      done_cnt <= done_cnt + 16'd1;
    end
  end

  assign A         = a_p0;
  assign B         = b_p0;
  assign OP        = op_p0;
  assign OUT_RES   = res_p1;
  assign ZERO      = zero_p1;
  assign ILLEGAL   = ill_p1;
  assign OUT_VALID = vld_p1;
  assign DONE_CNT  = done_cnt;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: behavioural ALU plus a transaction-level reference
// model checked every cycle, with directed literal checks and random traffic.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  sel;
  logic [5:0]  funct;
  logic [31:0] rs;
  logic [31:0] rt;
  logic [31:0] a;
  logic [31:0] b;
  logic [3:0]  op;
  logic [31:0] alu_res;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_res;
  logic        zero;
  logic        illegal;
  logic [15:0] done_cnt;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  alu_issue_ctrl dut (
    .CLK(clk), .RST_N(rst_n), .IN_VALID(in_valid), .IN_READY(in_ready),
    .ALU_OP_SEL(sel), .FUNCT(funct), .RS_DATA(rs), .RT_DATA(rt),
    .A(a), .B(b), .OP(op), .RES(alu_res),
    .OUT_VALID(out_valid), .OUT_READY(out_ready), .OUT_RES(out_res),
    .ZERO(zero), .ILLEGAL(illegal), .DONE_CNT(done_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // The ALU the block drives: combinational, returns 0 for unused codes.
  always_comb begin
    alu_res = '0;
    case (op)
      4'b0010: alu_res = a + b;
      4'b0110: alu_res = a - b;
      4'b0000: alu_res = a & b;
      4'b0001: alu_res = a | b;
      4'b0111: alu_res = (a < b) ? 32'd1 : 32'd0;
      4'b1100: alu_res = ~(a | b);
      default: alu_res = '0;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // What an instruction means: opcode, illegal flag and the result writeback sees.
  function automatic void ref_exec(input logic [1:0] s, input logic [5:0] f,
                                   input logic [31:0] x, input logic [31:0] y,
                                   output logic [3:0] o, output logic il,
                                   output logic [31:0] r);
    o = 4'hF; il = 1'b1; r = 32'd0;
    if (s == 2'b00) begin o = 4'h2; il = 1'b0; r = x + y; end
    else if (s == 2'b01) begin o = 4'h6; il = 1'b0; r = x - y; end
    else if (s == 2'b10) begin
      case (f)
        6'b100000: begin o = 4'h2; il = 1'b0; r = x + y; end
        6'b100010: begin o = 4'h6; il = 1'b0; r = x - y; end
        6'b100100: begin o = 4'h0; il = 1'b0; r = x & y; end
        6'b100101: begin o = 4'h1; il = 1'b0; r = x | y; end
        6'b101010: begin o = 4'h7; il = 1'b0; r = (x < y) ? 32'd1 : 32'd0; end
        6'b100111: begin o = 4'hC; il = 1'b0; r = ~(x | y); end
        default: ;
      endcase
    end
  endfunction

  // Transaction-level model: at most one instruction in flight or one result on show.
  bit          m_inflight, m_shown;
  logic [31:0] m_a, m_b, m_res, m_pend_res;
  logic [3:0]  m_op;
  logic        m_zero, m_ill, m_pend_ill;
  logic [15:0] m_cnt;
  bit          m_ready, m_take, m_acc;
  logic [3:0]  t_op;
  logic        t_ill;
  logic [31:0] t_res;

  initial begin
    m_inflight = 0; m_shown = 0; m_a = 0; m_b = 0; m_res = 0; m_pend_res = 0;
    m_op = 0; m_zero = 0; m_ill = 0; m_pend_ill = 0; m_cnt = 0;
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      m_inflight = 0; m_shown = 0; m_a = 0; m_b = 0; m_res = 0;
      m_op = 0; m_zero = 0; m_ill = 0; m_cnt = 0;
    end
    m_ready = rst_n && !m_inflight && (!m_shown || out_ready);
    chk("in_ready", in_ready, m_ready);
    chk("a", a, m_a);
    chk("b", b, m_b);
    chk("op", op, m_op);
    chk("out_valid", out_valid, m_shown);
    chk("out_res", out_res, m_res);
    chk("zero", zero, m_zero);
    chk("illegal", illegal, m_ill);
    chk("done_cnt", done_cnt, m_cnt);
    if (rst_n) begin
      m_take = m_shown && out_ready;
      m_acc  = in_valid && m_ready;
      if (m_inflight) begin
        m_inflight = 0;
        m_shown    = 1;
        m_res      = m_pend_res;
        m_zero     = (m_pend_res == 32'd0);
        m_ill      = m_pend_ill;
      end else if (m_take) begin
        m_shown = 0;
        m_cnt   = m_cnt + 16'd1;
      end
      if (m_acc) begin
        ref_exec(sel, funct, rs, rt, t_op, t_ill, t_res);
        m_a = rs; m_b = rt; m_op = t_op;
        m_pend_ill = t_ill; m_pend_res = t_res;
        m_inflight = 1;
      end
    end
  end

  // Offer an instruction and return #1 after the edge that accepted it.
  task automatic send(input logic [1:0] s, input logic [5:0] f,
                      input logic [31:0] x, input logic [31:0] y);
    bit rdy;
    rdy = 0;
    sel = s; funct = f; rs = x; rt = y; in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      #1;
      if (rdy) break;
    end
    if (!rdy) chk("accept_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic run_one(input string nm, input logic [1:0] s, input logic [5:0] f,
                         input logic [31:0] x, input logic [31:0] y,
                         input logic [3:0] e_op, input logic [31:0] e_res,
                         input logic e_zero, input logic e_ill);
    out_ready = 1'b1;
    send(s, f, x, y);
    chk({nm, "_op"}, op, e_op);
    @(posedge clk); #1;
    chk({nm, "_valid"}, out_valid, 1'b1);
    chk({nm, "_res"}, out_res, e_res);
    chk({nm, "_zero"}, zero, e_zero);
    chk({nm, "_ill"}, illegal, e_ill);
    @(posedge clk); #1;
  endtask

  logic [5:0] legal [6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b100111};
  int start_cyc;

  initial begin
    rst_n = 1'b1; in_valid = 0; out_ready = 0; sel = 0; funct = 0; rs = 0; rt = 0;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_ready", in_ready, 1'b1);
    chk("post_reset_cnt", done_cnt, 16'd0);
    @(posedge clk); #1;

    run_one("add", 2'b10, 6'b100000, 32'h5, 32'h7, 4'b0010, 32'hC, 1'b0, 1'b0);
    run_one("beq", 2'b01, 6'b000000, 32'h12345678, 32'h12345678, 4'b0110, 32'h0, 1'b1, 1'b0);
    run_one("slt", 2'b10, 6'b101010, 32'd3, 32'd9, 4'b0111, 32'h1, 1'b0, 1'b0);
    run_one("nor", 2'b10, 6'b100111, 32'hFFFF0000, 32'h000000FF, 4'b1100, 32'h0000FF00, 1'b0, 1'b0);
    run_one("ill_funct", 2'b10, 6'b000000, 32'h11, 32'h22, 4'b1111, 32'h0, 1'b1, 1'b1);
    run_one("ill_sel", 2'b11, 6'b100000, 32'h33, 32'h44, 4'b1111, 32'h0, 1'b1, 1'b1);
    chk("cnt_after_six", done_cnt, 16'd6);

    // Reset while an instruction is in EXEC.
    send(2'b00, 6'b0, 32'hAAAA, 32'h5555);
    rst_n = 1'b0;
    #1;
    chk("rst_ready", in_ready, 1'b0);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_a", a, 32'h0);
    chk("rst_op", op, 4'h0);
    chk("rst_res", out_res, 32'h0);
    chk("rst_cnt", done_cnt, 16'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rel_ready", in_ready, 1'b1);
    chk("rel_cnt", done_cnt, 16'd0);
    @(posedge clk); #1;

    // Backpressure, then four back-to-back results.
    out_ready = 1'b0;
    send(2'b00, 6'b0, 32'd1, 32'd2);
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_valid", out_valid, 1'b1);
      chk("bp_res", out_res, 32'd3);
      chk("bp_ready", in_ready, 1'b0);
    end
    start_cyc = cyc;
    out_ready = 1'b1;
    send(2'b10, 6'b100100, 32'hF0F0, 32'hFF00);
    send(2'b10, 6'b100101, 32'h0F00, 32'h00F0);
    send(2'b10, 6'b100010, 32'd10, 32'd4);
    for (int i = 0; i < 20 && done_cnt != 16'd4; i++) begin
      @(posedge clk); #1;
    end
    chk("b2b_cnt", done_cnt, 16'd4);
    chk("b2b_cycles", cyc - start_cyc, 7);

    // Counter wrap: preload a nearly full count.
    dut.done_cnt = 16'hFFFF;
    m_cnt = 16'hFFFF;
    run_one("wrap", 2'b00, 6'b0, 32'd8, 32'd8, 4'b0010, 32'd16, 1'b0, 1'b0);
    chk("wrap_cnt", done_cnt, 16'd0);

    // Random traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      rst_n     = ($urandom_range(0, 399) != 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      sel       = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b10;
      funct     = ($urandom_range(0, 7) < 6) ? legal[$urandom_range(0, 5)] : 6'($urandom);
      rs        = $urandom;
      rt        = ($urandom_range(0, 3) == 0) ? rs : $urandom;
    end
    @(posedge clk); #1;
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

Sequencing front end for the 32-bit ALU: accepts one decoded instruction (ALUOp class, funct field, two operands) per valid/ready handshake, and translates it into the ALU's 4-bit operation code. It drives the ALU's A/B/OP inputs from registers, captures the ALU's RES one cycle later, and presents the result with zero/illegal flags on an output valid/ready handshake. It sits between the decode/register-read stage and writeback in the multi-cycle datapath, and is the only master of the ALU.

## Interface
Parameters:
- None. Width is fixed at 32 bits.

Ports:
- CLK  in  1  single clock; all state updates on the rising edge.
- RST_N  in  1  reset, asynchronous, active-low.
- IN_VALID  in  1  an instruction is offered.
- IN_READY  out  1  the block accepts the offered instruction this cycle.
- ALU_OP_SEL  in  2  instruction class: 00 = add (load/store address), 01 = subtract (branch compare), 10 = R-type (use FUNCT), 11 = illegal.
- FUNCT  in  6  R-type function field; used only when ALU_OP_SEL = 10.
- RS_DATA  in  32  first operand.
- RT_DATA  in  32  second operand.
- A  out  32  registered ALU operand A.
- B  out  32  registered ALU operand B.
- OP  out  4  registered ALU operation code.
- RES  in  32  ALU result; combinational function of A, B and OP.
- OUT_VALID  out  1  OUT_RES, ZERO and ILLEGAL are valid.
- OUT_READY  in  1  the consumer takes the result.
- OUT_RES  out  32  captured result.
- ZERO  out  1  OUT_RES == 0.
- ILLEGAL  out  1  the instruction did not decode.
- DONE_CNT  out  16  count of completed output handshakes; wraps from 0xFFFF to 0.

## Operation
- Decode table (ALU_OP_SEL, FUNCT -> OP):
  - 00 -> 0010 (add).
  - 01 -> 0110 (subtract).
  - 10 with FUNCT 100000 -> 0010 (add).
  - 10 with FUNCT 100010 -> 0110 (subtract).
  - 10 with FUNCT 100100 -> 0000 (AND).
  - 10 with FUNCT 100101 -> 0001 (OR).
  - 10 with FUNCT 101010 -> 0111 (set-less-than, unsigned compare).
  - 10 with FUNCT 100111 -> 1100 (NOR).
- Any other combination sets OP = 1111 and latches ILLEGAL = 1. The ALU returns 0 for 1111, so OUT_RES = 0 and ZERO = 1 on an illegal instruction.
- State machine, states IDLE, EXEC, DONE:
  - IDLE: IN_READY = 1. When IN_VALID is high, register A <= RS_DATA, B <= RT_DATA, OP <= decoded value, and the illegal flag; go to EXEC.
  - EXEC: IN_READY = 0. Capture OUT_RES <= RES, ZERO <= (RES == 0) and ILLEGAL <= the latched flag; set OUT_VALID = 1; go to DONE.
  - DONE: OUT_VALID = 1 and all result outputs are held stable.
    - OUT_READY = 0: stay in DONE.
    - OUT_READY = 1 and IN_VALID = 0: increment DONE_CNT, clear OUT_VALID, go to IDLE.
    - OUT_READY = 1 and IN_VALID = 1: increment DONE_CNT, clear OUT_VALID, accept the new instruction as in IDLE, go to EXEC.
- IN_READY = (state == IDLE) || (state == DONE && OUT_READY). IN_READY is forced to 0 while RST_N is low.
- A, B and OP hold their last values outside an accept cycle, so the ALU inputs do not toggle while idle.
- Arithmetic is performed entirely in the ALU. This block does no arithmetic except the 16-bit DONE_CNT increment, which wraps modulo 2^16.

## Timing
- Reset: RST_N low asynchronously forces the following, which hold until the first CLK edge after RST_N rises:
  - state = IDLE;
  - A, B, OUT_RES = 0;
  - OP = 0000;
  - OUT_VALID, ZERO, ILLEGAL = 0;
  - DONE_CNT = 0.
- Latency: an instruction accepted at edge k drives the ALU from edge k; OUT_VALID rises at edge k+1.
- Throughput: one instruction per 2 cycles with OUT_READY held high and IN_VALID continuous.
- Backpressure: while OUT_READY = 0, OUT_VALID stays high, result outputs do not change, and IN_READY = 0.
- Reset mid-operation discards the in-flight instruction and its result; DONE_CNT does not count it.
- IN_VALID may drop without a handshake; the block samples inputs only when IN_VALID and IN_READY are both high.

## Test plan
- Reset check: RST_N = 0 mid-EXEC -> all outputs at their reset values immediately; IN_READY = 0; after release, IN_READY = 1 and DONE_CNT = 0.
- R-type ADD: SEL = 10, FUNCT = 100000, RS = 0x0000_0005, RT = 0x0000_0007 -> OP = 0010; one cycle later OUT_VALID = 1, OUT_RES = 0x0000_000C, ZERO = 0, ILLEGAL = 0.
- Branch subtract of equal operands: SEL = 01, RS = RT = 0x1234_5678 -> OP = 0110, OUT_RES = 0, ZERO = 1.
- SLT and NOR:
  - FUNCT 101010 with RS = 3, RT = 9 -> OUT_RES = 1.
  - FUNCT 100111 with RS = 0xFFFF_0000, RT = 0x0000_00FF -> OUT_RES = 0x0000_FF00.
- Illegal decode:
  - SEL = 10, FUNCT = 000000 -> OP = 1111, OUT_RES = 0, ZERO = 1, ILLEGAL = 1.
  - SEL = 11 -> same response.
- Backpressure and back-to-back: hold OUT_READY = 0 for 5 cycles -> outputs stable, IN_READY = 0. Then raise OUT_READY with IN_VALID high for 4 instructions -> one result every 2 cycles and DONE_CNT = 4. Preload 0xFFFF completions -> the next completion gives DONE_CNT = 0.
